// File: rtl/uart_pkg.sv
// Shared state encoding, parity codes and baud-rate helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int baud_div(input int clk_fre, input int clk_uart);
    return clk_fre / clk_uart;
  endfunction

  function automatic int baud_half(input int clk_fre, input int clk_uart);
    return baud_div(clk_fre, clk_uart) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; flags a dropped push as a one-cycle overrun.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      overrun <= push && !do_push;
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: synchroniser, mid-bit sampling FSM with error flags, output FIFO.
module uart_rx_frame import uart_pkg::*; #(
  parameter int CLK_FRE    = 50000000,
  parameter int CLK_UART   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic                          rx_valid,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV  = baud_div(CLK_FRE, CLK_UART);
  localparam int HALF = baud_half(CLK_FRE, CLK_UART);
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  generate
    if (DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_cfg
      $error("uart_rx_frame: illegal parameter combination");
    end
  endgenerate

  rx_state_t            state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 perr;
  logic                 ferr;
  logic                 all_zero;
  logic                 baud_done;
  logic                 parity_exp;
  logic                 last_stop;
  logic [DATA_BITS+1:0] push_data;
  logic [DATA_BITS+1:0] head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign baud_done  = (baud_cnt == DIV_LAST);
  assign parity_exp = (PARITY == PARITY_ODD) ? ~(^shift) : ^shift;
  assign last_stop  = enable && (state == S_STOP) && baud_done && (bit_cnt == STOP_LAST);
  // The final stop sample is folded in here so the entry is pushed on that same edge.
  assign push_data  = {ferr | ~rx_s, perr, shift};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      all_zero <= 1'b0;
    end else if (!enable) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            all_zero <= 1'b1;
            state    <= rx_s ? S_IDLE : S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[DATA_BITS-1:1]};
            if (rx_s) all_zero <= 1'b0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY == PARITY_NONE) ? S_STOP : S_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            perr     <= rx_s ^ parity_exp;
            if (rx_s) all_zero <= 1'b0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (!rx_s) ferr <= 1'b1;
            else       all_zero <= 1'b0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= (all_zero && !rx_s) ? S_BREAK : S_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (last_stop),
    .push_data (push_data),
    .pop       (rd_en),
    .head      (head),
    .count     (fifo_count),
    .overrun   (overrun)
  );

  assign rx_valid = (fifo_count != '0);
  assign rx_data  = head[DATA_BITS-1:0];
  assign rx_perr  = head[DATA_BITS];
  assign rx_ferr  = head[DATA_BITS+1];

endmodule
